// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with valid/ready handshake, optional two-entry skid
// buffer, flush, and a saturating stall-cycle counter for performance debug.
module id_exe_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ALUC_W = 3,
    parameter int RN_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_aluimm,
    input  logic              id_shift,
    input  logic              id_wreg,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic [DATA_W-1:0] id_ra,
    input  logic [DATA_W-1:0] id_rb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RN_W-1:0]   id_rn,
    input  logic              flush,
    output logic              exe_valid,
    input  logic              exe_ready,
    output logic              exe_m2reg,
    output logic              exe_wmem,
    output logic              exe_aluimm,
    output logic              exe_shift,
    output logic              exe_wreg,
    output logic [ALUC_W-1:0] exe_aluc,
    output logic [DATA_W-1:0] exe_ra,
    output logic [DATA_W-1:0] exe_rb,
    output logic [DATA_W-1:0] exe_imm,
    output logic [RN_W-1:0]   exe_rn,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BUS_W = 5 + ALUC_W + 3 * DATA_W + RN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [BUS_W-1:0]   w_idBus;
    logic [BUS_W-1:0]   r_main;
    logic [BUS_W-1:0]   r_skid;
    logic               w_accept;
    logic               w_issue;
    logic               w_loadMain;
    logic               w_loadSkid;
    logic               w_mainFromSkid;
    logic               w_wmem;
    logic               w_wreg;
    logic [CNT_W-1:0]   r_stallCnt;

    assign w_idBus  = {id_m2reg, id_wmem, id_aluimm, id_shift, id_wreg,
                       id_aluc, id_ra, id_rb, id_imm, id_rn};
    assign w_accept = id_valid & id_ready;
    assign w_issue  = exe_valid & exe_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush drops everything, including an instruction accepted this cycle.
    always_comb begin
        w_nextState    = r_state;
        w_loadMain     = 1'b0;
        w_loadSkid     = 1'b0;
        w_mainFromSkid = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_nextState = ONE;
                        w_loadMain  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_issue) begin
                        w_loadMain = 1'b1;
                    end else if (w_accept) begin
                        if (SKID != 0) begin
                            w_nextState = FULL;
                            w_loadSkid  = 1'b1;
                        end
                    end else if (w_issue) begin
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_issue) begin
                        w_nextState    = ONE;
                        w_mainFromSkid = 1'b1;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        exe_valid = (r_state != EMPTY);
    end

    generate
        if (SKID != 0) begin : g_skidReady
            logic r_idReady;
            // Registered so a downstream stall never reaches decode combinationally.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_idReady <= 1'b1;
                end else begin
                    r_idReady <= (w_nextState != FULL);
                end
            end
            assign id_ready = r_idReady;
        end else begin : g_combReady
            assign id_ready = exe_ready | ~exe_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_mainFromSkid) begin
                r_main <= r_skid;
            end else if (w_loadMain) begin
                r_main <= w_idBus;
            end
            if (w_loadSkid) begin
                r_skid <= w_idBus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_stallCnt <= '0;
        end else if (exe_valid && !exe_ready && !flush && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    // Bubbles must never write, so the write enables are qualified by valid.
    assign {exe_m2reg, w_wmem, exe_aluimm, exe_shift, w_wreg,
            exe_aluc, exe_ra, exe_rb, exe_imm, exe_rn} = r_main;
    assign exe_wmem  = w_wmem & exe_valid;
    assign exe_wreg  = w_wreg & exe_valid;
    assign stall_cnt = r_stallCnt;

endmodule
